// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - signed radix-2 Booth sequential multiplier, one add/subtract per cycle
module mult_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic [31:0] result,
  output logic        overflow,
  output logic        busy,
  output logic        ready
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] m_q, m_d;
  logic [64:0] p_q, p_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        overflow_q, overflow_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;

  logic [32:0] m_ext;
  logic [32:0] addend;
  logic        carry_in;
  logic [32:0] acc_sum;

  always_comb begin
    // 33-bit sign-extended accumulate keeps M = 0x80000000 exact under negation
    m_ext    = {m_q[31], m_q};
    addend   = '0;
    carry_in = 1'b0;
    case (p_q[1:0])
      2'b01: addend = m_ext;
      2'b10: begin
        addend   = ~m_ext;
        carry_in = 1'b1;
      end
      default: addend = '0;
    endcase
    acc_sum = {p_q[64], p_q[64:33]} + addend + {32'b0, carry_in};

    state_d    = state_q;
    m_d        = m_q;
    p_d        = p_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          m_d     = operand_a;
          p_d     = {32'b0, operand_b, 1'b0};
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (cnt_q == 6'd32) begin
          state_d    = DONE;
          result_d   = p_q[32:1];
          overflow_d = ~((&p_q[64:32]) | ~(|p_q[64:32]));
        end else begin
          p_d   = {acc_sum, p_q[32:1]};
          cnt_d = cnt_q + 6'd1;
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          m_d     = operand_a;
          p_d     = {32'b0, operand_b, 1'b0};
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The load cycle of RUN is not counted as busy; busy spans the 32 iterations
    busy_d  = (state_d == RUN) && (cnt_d != 6'd0);
    ready_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      m_q        <= '0;
      p_q        <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      p_q        <= p_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  assign result   = result_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;
  assign ready    = ready_q;

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 SHALL use one clock, `clock`; reset, `reset`, SHALL be synchronous and active-high.
REQ-002 Ports (name, direction, width, meaning):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- start  in  1  request a multiply; sampled each rising edge
- operand_a  in  32  multiplicand, two's complement
- operand_b  in  32  multiplier, two's complement
- result  out  32  low 32 bits of the signed product
- overflow  out  1  signed 64-bit product does not fit in 32 bits
- busy  out  1  iteration in progress
- ready  out  1  one-cycle pulse: result/overflow newly valid

Function
REQ-003 SHALL be a signed radix-2 Booth multiplier with one add/subtract per cycle.
REQ-004 States SHALL be IDLE, RUN, DONE; the reset state is IDLE.
REQ-005 Transitions:
- IDLE -> RUN when start=1.
- RUN -> DONE when the step counter reaches 32.
- DONE -> RUN when start=1; otherwise DONE -> IDLE.
REQ-006 On an accepted start (IDLE or DONE with start=1):
- M <= operand_a.
- Product register P (65 bits) <= {32'b0, operand_b, 1'b0}.
- Step counter <= 0.
REQ-007 Each RUN cycle, with q = {P[1], P[0]}:
- 01: P[64:33] += M.
- 10: P[64:33] -= M, done as add of ~M with carry-in 1.
- 00 or 11: no change.
- Then P arithmetic-shifts right 1 and the counter increments.
REQ-008 The accumulate SHALL use a 33-bit sign-extended adder so that M = 0x80000000 is exact.
REQ-009 After exactly 32 RUN cycles, product = P[64:1].
- result SHALL equal P[32:1].
- overflow SHALL be 1 iff P[64:32] bits are not all equal.
REQ-010 Latency: start accepted at edge N -> busy=1 after edges N+1..N+32 -> ready=1 and busy=0 for exactly the cycle after edge N+33.
REQ-011 busy SHALL be 1 only in RUN; ready SHALL be 1 only in DONE.
REQ-012 result and overflow SHALL update only on entry to DONE and SHALL hold until the next DONE entry or reset.
REQ-013 start asserted while busy=1 SHALL be ignored; the operation in progress and its operands are unaffected.
REQ-014 operand_a and operand_b SHALL be sampled only at the accepting edge; later changes have no effect.
REQ-015 start held high continuously SHALL yield back-to-back operations: one DONE cycle, then immediate re-entry to RUN.
REQ-016 Zero operands SHALL take the full 32 cycles; there is no early termination.

Reset
REQ-017 reset=1 at any rising edge, including mid-RUN, SHALL force:
- state IDLE;
- busy=0, ready=0, result=0, overflow=0;
- P, M and counter to 0.
The in-flight operation is discarded.
REQ-018 reset SHALL take priority over start at the same edge.
REQ-019 The first start after reset deasserts SHALL be accepted normally.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- a=3, b=5, start one cycle -> ready pulse 33 edges later, result=0x0000000F, overflow=0, busy high exactly 32 cycles.
- a=-7 (0xFFFFFFF9), b=6 -> result=0xFFFFFFD6, overflow=0.
- a=0x80000000, b=0xFFFFFFFF -> result=0x80000000, overflow=1; and a=0x80000000, b=1 -> result=0x80000000, overflow=0.
- a=0x00010000, b=0x00010000 -> result=0x00000000, overflow=1.
- Start 3*5; at RUN cycle 10 assert start with a=100, b=100 -> ignored; result=15 at the original ready time.
- Start 9*9; reset at RUN cycle 16 -> next cycle busy=0, ready=0, result=0; then start 2*2 -> result=4 after 33 edges.
REQ-021 The bench SHALL compare result/overflow against a 64-bit signed reference model for at least 1000 random operand pairs, including back-to-back starts, and SHALL check REQ-010 timing on every operation.
